hazard_pipe_regs: RTL

Front-end pipeline register bank that consumes the stall/flush controls produced by the hazard logic. It holds the fetch PC, the IF/ID register and the ID/EX register, and applies StallF/StallD/FlushD/FlushE with a fixed priority. It also keeps saturating stall/flush/bubble counters and a sticky protocol-error flag. It sits between fetch/decode datapath logic and the EX stage of the 5-stage MIPS core.

---
 rtl/hazard_pipe_regs.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_pipe_regs.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX) driven by hazard-unit stall/flush controls,
// with saturating stall/flush/bubble counters and a sticky protocol-error flag.
module hazard_pipe_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CTRL_W   = 12,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  input  logic [31:0]       SrcAD,
  input  logic [31:0]       SrcBD,
  input  logic [31:0]       SignImmD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic [31:0]       SrcAE,
  output logic [31:0]       SrcBE,
  output logic [31:0]       SignImmE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  BubbleCnt,
  output logic              ProtoErr
);

  logic [CNT_W-1:0] stallCntNext, flushCntNext, bubbleCntNext;
  logic             flushDEff;
  logic             protoErrNext;

  // A flush while D is stalled belongs to an unresolved branch and is ignored.
  assign flushDEff = FlushD & ~StallD;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
    return (en && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
  endfunction

  always_comb begin
    stallCntNext  = satInc(StallCnt, StallF);
    flushCntNext  = satInc(FlushCnt, flushDEff);
    bubbleCntNext = satInc(BubbleCnt, FlushE);
    // Stalling only one of F/D either drops or duplicates an instruction.
    protoErrNext  = ProtoErr | (StallF ^ StallD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (FlushD) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CtrlE    <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      SrcAE    <= '0;
      SrcBE    <= '0;
      SignImmE <= '0;
      ValidE   <= 1'b0;
    end else if (FlushE) begin
      CtrlE    <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      SrcAE    <= '0;
      SrcBE    <= '0;
      SignImmE <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
      SrcAE    <= SrcAD;
      SrcBE    <= SrcBD;
      SignImmE <= SignImmD;
      ValidE   <= ValidD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt  <= '0;
      FlushCnt  <= '0;
      BubbleCnt <= '0;
      ProtoErr  <= 1'b0;
    end else begin
      StallCnt  <= stallCntNext;
      FlushCnt  <= flushCntNext;
      BubbleCnt <= bubbleCntNext;
      ProtoErr  <= protoErrNext;
    end
  end

endmodule
